mpu_elementwise_alu: RTL
========================

Name: mpu_elementwise_alu

Overview:
Sequential, parametrised element-wise matrix ALU for the MPU. It computes ADD, SUB or NEG over an N x N matrix of signed W-bit elements, LANES elements per cycle, with a start/busy/done handshake. It also reports a sticky overflow flag. It replaces the fixed 5x5 combinational subtractor in the MPU datapath.

Parameters:
N, 5, matrix dimension (N x N elements), N >= 1
W, 8, element width in bits, signed two's complement, W >= 2
LANES, 5, elements processed per cycle, 1 <= LANES <= N*N

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  00 ADD (a+b), 01 SUB (a-b), 10 NEG (-a), 11 PASS (a)
matrix_a  in  W*N*N  flattened operand A; element (r,c) at [(r*N+c)*W +: W]
matrix_b  in  W*N*N  flattened operand B, same layout
result  out  W*N*N  flattened result, same layout, registered
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse when result is complete
overflow  out  1  sticky: any element overflowed during the current operation

Behaviour:
- Reset (async, rst_n=0): state IDLE, result=0, busy=0, done=0, overflow=0, element index idx=0, operand latches=0.
- States are IDLE, RUN and DONE.
- IDLE with start=1 at a clock edge:
  - latch matrix_a, matrix_b and op into internal registers;
  - clear result to 0 and overflow to 0;
  - idx=0; go to RUN.
  - Inputs are not sampled again until the next accepted start.
- RUN, each cycle:
  - for lane l in 0..LANES-1, k=idx+l; if k<N*N, write result element k from the latched operands;
  - overflow |= any lane overflow;
  - idx += LANES;
  - if idx+LANES >= N*N, go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE next cycle; busy drops with done.
- RUN length R = ceil(N*N/LANES) cycles. done is high in cycle R+1 after the accepting edge. Default config: R=5, so done appears 6 cycles after start.
- start while busy is ignored: no restart and no latch update.
- result holds its final value after DONE until the next accepted start.
- Arithmetic:
  - sign-extend operands to W+1 bits and compute the exact value;
  - element overflow = bit W differs from bit W-1;
  - stored value = low W bits (wrap), unless saturation is enabled.
  - NEG of the most negative value (-2^(W-1)) overflows.
  - PASS never overflows.
- Partial last cycle: lanes with k >= N*N neither write nor contribute to overflow.
- Reset mid-operation: abort immediately to the reset state. No done pulse. Next start proceeds normally.
- matrix_a and matrix_b changing during RUN have no effect on the result.

Optional Feature:
MPU_SAT_EN:
- Defined: overflowing elements clamp to +2^(W-1)-1 or -2^(W-1) according to the sign of the exact (W+1)-bit value. The overflow flag is still set.
- Undefined: overflowing elements wrap (low W bits). The flag behaves identically.

Test Plan:
1. Defaults; A(k)=k+1, B(k)=25-k, op=SUB, pulse start -> done in cycle 6 after start, result(k)=2k-24 (-24,-22,...,24), overflow=0, busy high cycles 1-6.
2. All A=100, B=100, op=ADD -> without MPU_SAT_EN every element -56; with MPU_SAT_EN every element 127; overflow=1 in both builds.
3. A(0)=-128, all others 3, op=NEG -> element 0 is -128 (wrap) or 127 (sat), others -3, overflow=1. Same A with op=PASS -> result=A, overflow=0.
4. Start SUB from scenario 1; at cycle 2 drive start=1, op=ADD and new operands -> ignored, done still at cycle 6, result as in scenario 1, exactly one done pulse.
5. Assert rst_n=0 at cycle 3 of RUN -> result=0, busy=0, done=0, overflow=0 immediately; after release, scenario 1 completes with correct result and timing.
6. Build with LANES=3, N=5, scenario 1 stimulus -> 9 RUN cycles, only lane 0 writes in the last cycle, done in cycle 10, result identical to scenario 1.

Source files
------------

// File: rtl/mpu_elementwise_alu.sv
// Sequential element-wise matrix ALU (ADD/SUB/NEG/PASS), LANES elements per cycle, sticky overflow.
// Define MPU_SAT_EN to clamp overflowing elements instead of wrapping them.
module mpu_elementwise_alu #(
    parameter int N     = 5,
    parameter int W     = 8,
    parameter int LANES = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [W*N*N-1:0]     matrix_a,
    input  logic [W*N*N-1:0]     matrix_b,
    output logic [W*N*N-1:0]     result,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    localparam int NE = N * N;
    localparam int IW = $clog2(NE + LANES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [IW-1:0]       r_idx;
    logic [1:0]          r_op;
    logic [W*NE-1:0]     r_a, r_b, r_result;
    logic                r_ovf;
    logic [W*NE-1:0]     w_result;
    logic                w_lane_ovf;
    logic signed [W:0]   w_ex;
    int                  w_k;

    // Exact (W+1)-bit value of one element operation.
    function automatic logic signed [W:0] exact(input logic [1:0] f_op,
                                                input logic signed [W-1:0] f_a,
                                                input logic signed [W-1:0] f_b);
        logic signed [W:0] ea, eb;
        ea = {f_a[W-1], f_a};
        eb = {f_b[W-1], f_b};
        case (f_op)
            2'b00:   return ea + eb;
            2'b01:   return ea - eb;
            2'b10:   return -ea;
            default: return ea;
        endcase
    endfunction

    function automatic logic [W-1:0] resolve(input logic signed [W:0] f_ex);
        logic [W-1:0] v;
        v = f_ex[W-1:0];
`ifdef MPU_SAT_EN
        if (f_ex[W] != f_ex[W-1])
            v = f_ex[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return v;
    endfunction

    // Lanes past the last element neither write nor flag overflow.
    always_comb begin
        w_result   = r_result;
        w_lane_ovf = 1'b0;
        w_ex       = '0;
        w_k        = 0;
        for (int l = 0; l < LANES; l++) begin
            w_k = int'(r_idx) + l;
            if (w_k < NE) begin
                w_ex = exact(r_op, r_a[w_k*W +: W], r_b[w_k*W +: W]);
                w_result[w_k*W +: W] = resolve(w_ex);
                w_lane_ovf = w_lane_ovf | (w_ex[W] ^ w_ex[W-1]);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (int'(r_idx) + LANES >= NE) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_a      <= matrix_a;
                r_b      <= matrix_b;
                r_op     <= op;
                r_result <= '0;
                r_ovf    <= 1'b0;
                r_idx    <= '0;
            end else if (r_state == S_RUN) begin
                r_result <= w_result;
                r_ovf    <= r_ovf | w_lane_ovf;
                r_idx    <= r_idx + IW'(LANES);
            end
        end
    end

    assign result   = r_result;
    assign overflow = r_ovf;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
endmodule
